i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  Parametrised byte-level register engine behind the I2C slave core: interprets received bytes as
//  register pointer plus write data and feeds read bytes back on each send request.
//  Successor to the fixed chip-id/int16 driver: N registers of REG_BYTES bytes, write support,
//  auto-increment with wrap, multi-byte burst reads/writes. Sits between I2C slave core and user logic.
// PARAMETERS
//  SLAVE_ADDRESS  7'h3C  7-bit bus address driven on `address`
//  NUM_REGS       16     register count, 2..256; pointer width PW = clog2(NUM_REGS)
//  REG_BYTES      2      bytes per register, 1..4; register width RW = 8*REG_BYTES
//  CHIP_ID        8'hA5  value of reg 0 (read-only), zero-extended to RW
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  address      out  7       constant SLAVE_ADDRESS
//  busy         in   1       high while slave core is in an addressed transaction (START..STOP)
//  datareceive  in   8       byte from core, valid when received rises
//  received     in   1       level; rising edge = new byte received
//  datasend     out  8       next byte to transmit
//  sended       in   1       level; rising edge = previous byte shifted out, next requested
//  status_in    in   RW      live value returned for reg 1 (read-only)
//  regs_q       out  NUM_REGS*RW  flat register file, reg k at [k*RW +: RW]
//  wr_stb       out  1       one-cycle pulse when a full register write commits
//  wr_idx       out  PW      index of committed register, valid with wr_stb
//  err          out  1       sticky: write to RO reg, pointer >= NUM_REGS, or rcv/send collision
//  err_clr      in   1       clears err
// BEHAVIOUR
//  Reset: datasend=0, regs_q=0 (reg 0 reads CHIP_ID, not stored), wr_stb=0, wr_idx=0, err=0,
//   ptr=0, byte_idx=0, FSM=IDLE. Reset mid-transfer discards everything; no partial commit.
//  Edge detect: received/sended sampled into last_* flops each clk; rise = cur & ~last.
//  FSM: IDLE -(busy rise)-> PTR; PTR -(rcv rise)-> ptr<=byte[PW-1:0], byte_idx=0, preload -> DATA;
//   DATA: rcv rise = write byte, send rise = read byte; any state -(busy fall)-> IDLE.
//   Pointer byte >= NUM_REGS: err=1, ptr=0.
//  Byte order: MSB first; byte_idx counts 0..REG_BYTES-1.
//  Write: bytes collected into shadow reg; on byte_idx==REG_BYTES-1 commit to regs_q[ptr],
//   wr_stb=1 next cycle with wr_idx=ptr, then ptr increments. Writes to reg 0/1 not stored, err=1,
//   ptr still advances. Partial register at busy fall is discarded, no wr_stb.
//  Read: source = CHIP_ID (0), status_in (1, snapshot taken at byte_idx 0), regs_q[ptr] else.
//   datasend loaded with current byte 2 clk after pointer rcv rise (preload) and 2 clk after each
//   send rise (advance byte_idx, then load). After last byte of a register ptr increments.
//  Wrap: ptr NUM_REGS-1 -> 0 on increment, no error.
//  Collision: rcv rise and send rise in same clk -> receive handled, send ignored, err=1.
//  err_clr and new error same clk: error wins. Rises while IDLE ignored.
// STRUCTURE
//  Shared header i2c_slave_defs.vh: FSM state encodings (IDLE/PTR/DATA), ZERO8, RO reg indices.
//  Sub-module i2c_level_edge (one flop + AND, per input) instanced for received, sended, busy.
//  Main module: FSM, pointer/byte counters, shadow write reg, read mux, register file.
// TESTING
//  Defaults. Write ptr 8'h04, bytes 8'h12,8'h34 -> wr_stb once, wr_idx=4, reg4=16'h1234, err=0.
//  Ptr 8'h00, two send rises -> datasend 8'h00 after preload, then 8'hA5; ptr ends at 1.
//  Ptr 8'h0F, write 4 bytes AA BB CC DD -> reg15=AABB, reg0 unchanged, err=1 (RO wrap), ptr=1.
//  Ptr 8'h05, single byte 8'h77 then busy fall -> no wr_stb, reg5 unchanged, FSM IDLE.
//  status_in=16'hBEEF, ptr 1, read 2 bytes -> BE, EF; ptr 8'h20 -> err=1, err_clr -> err=0.
//  Assert reset during 2nd byte of write -> all outputs at reset values, no wr_stb.

Source files
------------

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared definitions for the I2C slave register engine: FSM states,
// byte constants and read-only register indices.
package i2c_slave_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PTR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [7:0] ZERO8          = 8'h00;
  localparam int         RO_CHIP_ID_IDX = 0;
  localparam int         RO_STATUS_IDX  = 1;

  function automatic logic is_ro(input int idx);
    return (idx == RO_CHIP_ID_IDX) || (idx == RO_STATUS_IDX);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile_edge.sv
// Level-to-edge converter: one history flop, rise/fall derived combinationally
// against the live level.
module i2c_level_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b0;
    end else begin
      last_q <= level_i;
    end
  end

  assign rise_o = level_i & ~last_q;
  assign fall_o = ~level_i & last_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Byte-level register engine behind an I2C slave core: pointer byte, then
// MSB-first burst writes/reads with auto-increment and wrap.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h3C,
  parameter int         NUM_REGS      = 16,
  parameter int         REG_BYTES     = 2,
  parameter logic [7:0] CHIP_ID       = 8'hA5,
  localparam int        PW            = $clog2(NUM_REGS),
  localparam int        RW            = 8 * REG_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [6:0]             address,
  input  logic                   busy,
  input  logic [7:0]             datareceive,
  input  logic                   received,
  output logic [7:0]             datasend,
  input  logic                   sended,
  input  logic [RW-1:0]          status_in,
  output logic [NUM_REGS*RW-1:0] regs_q,
  output logic                   wr_stb,
  output logic [PW-1:0]          wr_idx,
  output logic                   err,
  input  logic                   err_clr
);

  localparam logic [1:0]    LAST_IDX = 2'(REG_BYTES - 1);
  localparam logic [PW-1:0] TOP_PTR  = PW'(NUM_REGS - 1);

  logic rcv_rise_s, snd_rise_s, busy_rise_s, busy_fall_s;
  logic unused_rcv_fall_s, unused_snd_fall_s, unused_busy_rise_s;

  i2c_level_edge u_rcv_edge  (.clk_i(clk), .rst_i(reset), .level_i(received),
                              .rise_o(rcv_rise_s), .fall_o(unused_rcv_fall_s));
  i2c_level_edge u_snd_edge  (.clk_i(clk), .rst_i(reset), .level_i(sended),
                              .rise_o(snd_rise_s), .fall_o(unused_snd_fall_s));
  i2c_level_edge u_busy_edge (.clk_i(clk), .rst_i(reset), .level_i(busy),
                              .rise_o(busy_rise_s), .fall_o(busy_fall_s));
  assign unused_busy_rise_s = 1'b0;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, next_ptr_s, wr_idx_q, wr_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [RW-1:0] shadow_q, shadow_d, wdata_s, snap_q, src_s;
  logic [RW-1:0] mem_q [NUM_REGS];
  logic [7:0]    datasend_q, byte_s;
  logic          load_q, load_d, wr_stb_q, wr_stb_d, err_q, err_d, new_err_s, mem_we_s;

  assign next_ptr_s = (ptr_q == TOP_PTR) ? '0 : ptr_q + 1'b1;
  assign wdata_s    = (shadow_q << 8) | RW'(datareceive);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    load_d     = 1'b0;
    wr_stb_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    new_err_s  = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_idx_d = 2'd0;
        if (busy_rise_s) begin
          state_d = ST_PTR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PTR: begin
        if (busy_fall_s) begin
          state_d = ST_IDLE;
        end else if (rcv_rise_s) begin
          if ({1'b0, datareceive} >= 9'(NUM_REGS)) begin
            ptr_d     = '0;
            new_err_s = 1'b1;
          end else begin
            ptr_d = datareceive[PW-1:0];
          end
          new_err_s  = new_err_s | snd_rise_s;
          byte_idx_d = 2'd0;
          load_d     = 1'b1;
          state_d    = ST_DATA;
        end else begin
          state_d = ST_PTR;
        end
      end
      ST_DATA: begin
        if (busy_fall_s) begin
          state_d    = ST_IDLE;
          byte_idx_d = 2'd0;
        end else if (rcv_rise_s) begin
          // Receive wins a collision; the simultaneous send request is dropped.
          new_err_s = snd_rise_s;
          shadow_d  = wdata_s;
          if (byte_idx_q == LAST_IDX) begin
            if (is_ro(int'(ptr_q))) begin
              new_err_s = 1'b1;
            end else begin
              mem_we_s = 1'b1;
              wr_stb_d = 1'b1;
              wr_idx_d = ptr_q;
            end
            ptr_d      = next_ptr_s;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (snd_rise_s) begin
          if (byte_idx_q == LAST_IDX) begin
            ptr_d      = next_ptr_s;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
          load_d = 1'b1;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (new_err_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Status register is snapshotted on its first byte so a burst stays coherent.
  always_comb begin
    src_s = mem_q[ptr_q];
    if (ptr_q == PW'(RO_CHIP_ID_IDX)) begin
      src_s = RW'(CHIP_ID);
    end else if (ptr_q == PW'(RO_STATUS_IDX)) begin
      src_s = (byte_idx_q == 2'd0) ? status_in : snap_q;
    end else begin
      src_s = mem_q[ptr_q];
    end
    byte_s = src_s[8*(REG_BYTES-1-int'(byte_idx_q)) +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      byte_idx_q <= 2'd0;
      shadow_q   <= '0;
      snap_q     <= '0;
      load_q     <= 1'b0;
      datasend_q <= ZERO8;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      load_q     <= load_d;
      wr_stb_q   <= wr_stb_d;
      wr_idx_q   <= wr_idx_d;
      err_q      <= err_d;
      if (load_q) begin
        datasend_q <= byte_s;
        if (byte_idx_q == 2'd0) begin
          snap_q <= status_in;
        end
      end
      if (mem_we_s) begin
        mem_q[ptr_q] <= wdata_s;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_q[k*RW +: RW] = mem_q[k];
  end

  assign address  = SLAVE_ADDRESS;
  assign datasend = datasend_q;
  assign wr_stb   = wr_stb_q;
  assign wr_idx   = wr_idx_q;
  assign err      = err_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile with default parameters (16 x 16-bit).
module tb_i2c_slave_regfile;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   address;
  logic         busy = 1'b0;
  logic [7:0]   datareceive = 8'h00;
  logic         received = 1'b0;
  logic [7:0]   datasend;
  logic         sended = 1'b0;
  logic [15:0]  status_in = 16'h0000;
  logic [255:0] regs_q;
  logic         wr_stb;
  logic [3:0]   wr_idx;
  logic         err;
  logic         err_clr = 1'b0;

  int checks = 0;
  int passes = 0;
  int stb_cnt = 0;
  logic [3:0] stb_idx = 4'd0;

  i2c_slave_regfile dut (
    .clk(clk), .reset(reset), .address(address), .busy(busy),
    .datareceive(datareceive), .received(received), .datasend(datasend),
    .sended(sended), .status_in(status_in), .regs_q(regs_q),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt = stb_cnt + 1;
      stb_idx = wr_idx;
    end
  end

  function automatic logic [15:0] reg_at(input int k);
    return regs_q[k*16 +: 16];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xfer();
    busy = 1'b1; tick(2);
  endtask

  task automatic stop_xfer();
    busy = 1'b0; tick(2);
  endtask

  task automatic rcv(input logic [7:0] b);
    datareceive = b; received = 1'b1; tick(2);
    received = 1'b0; tick(2);
  endtask

  task automatic snd();
    sended = 1'b1; tick(2);
    sended = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3);
    checks++; if (datasend !== 8'h00) $display("FAIL reset_datasend got %h want 00", datasend); else passes++;
    checks++; if (regs_q !== 256'h0) $display("FAIL reset_regs got %h want 0", regs_q); else passes++;
    checks++; if (wr_stb !== 1'b0 || err !== 1'b0) $display("FAIL reset_flags got stb=%b err=%b want 0 0", wr_stb, err); else passes++;
    checks++; if (address !== 7'h3C) $display("FAIL address got %h want 3c", address); else passes++;
    reset = 1'b0; tick(2);
  endtask

  task automatic test_write();
    int c0;
    c0 = stb_cnt;
    start_xfer(); rcv(8'h04); rcv(8'h12); rcv(8'h34);
    checks++; if (stb_cnt - c0 !== 1 || stb_idx !== 4'd4) $display("FAIL write_stb got cnt=%0d idx=%0d want 1 4", stb_cnt - c0, stb_idx); else passes++;
    checks++; if (reg_at(4) !== 16'h1234) $display("FAIL write_reg4 got %h want 1234", reg_at(4)); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL write_err got %b want 0", err); else passes++;
    stop_xfer();
  endtask

  task automatic test_read_chipid();
    status_in = 16'h5A3C;
    start_xfer(); rcv(8'h00);
    checks++; if (datasend !== 8'h00) $display("FAIL chip_preload got %h want 00", datasend); else passes++;
    snd();
    checks++; if (datasend !== 8'hA5) $display("FAIL chip_byte1 got %h want a5", datasend); else passes++;
    snd();
    checks++; if (datasend !== 8'h5A) $display("FAIL chip_next_ptr got %h want 5a", datasend); else passes++;
    stop_xfer();
  endtask

  task automatic test_wrap();
    int c0;
    c0 = stb_cnt;
    start_xfer(); rcv(8'h0F); rcv(8'hAA); rcv(8'hBB); rcv(8'hCC); rcv(8'hDD);
    checks++; if (reg_at(15) !== 16'hAABB) $display("FAIL wrap_reg15 got %h want aabb", reg_at(15)); else passes++;
    checks++; if (reg_at(0) !== 16'h0000) $display("FAIL wrap_reg0 got %h want 0000", reg_at(0)); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL wrap_err got %b want 1", err); else passes++;
    checks++; if (stb_cnt - c0 !== 1 || stb_idx !== 4'd15) $display("FAIL wrap_stb got cnt=%0d idx=%0d want 1 15", stb_cnt - c0, stb_idx); else passes++;
    rcv(8'h11); rcv(8'h22); rcv(8'h33); rcv(8'h44);
    checks++; if (reg_at(2) !== 16'h3344 || reg_at(1) !== 16'h0000) $display("FAIL wrap_ptr_advance got r1=%h r2=%h want 0000 3344", reg_at(1), reg_at(2)); else passes++;
    checks++; if (stb_cnt - c0 !== 2 || stb_idx !== 4'd2) $display("FAIL wrap_stb2 got cnt=%0d idx=%0d want 2 2", stb_cnt - c0, stb_idx); else passes++;
    stop_xfer();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    checks++; if (err !== 1'b0) $display("FAIL wrap_errclr got %b want 0", err); else passes++;
  endtask

  task automatic test_partial();
    int c0;
    c0 = stb_cnt;
    start_xfer(); rcv(8'h05); rcv(8'h77); stop_xfer();
    checks++; if (stb_cnt - c0 !== 0 || reg_at(5) !== 16'h0000) $display("FAIL partial got cnt=%0d r5=%h want 0 0000", stb_cnt - c0, reg_at(5)); else passes++;
    rcv(8'h99);
    start_xfer(); rcv(8'h05); rcv(8'h66); rcv(8'h88); stop_xfer();
    checks++; if (reg_at(5) !== 16'h6688) $display("FAIL partial_discard got %h want 6688", reg_at(5)); else passes++;
  endtask

  task automatic test_status();
    status_in = 16'hBEEF;
    start_xfer(); rcv(8'h01);
    checks++; if (datasend !== 8'hBE) $display("FAIL status_b0 got %h want be", datasend); else passes++;
    status_in = 16'h1234;
    snd();
    checks++; if (datasend !== 8'hEF) $display("FAIL status_snap got %h want ef", datasend); else passes++;
    stop_xfer();
    start_xfer(); rcv(8'h20);
    checks++; if (err !== 1'b1) $display("FAIL ptr_range_err got %b want 1", err); else passes++;
    stop_xfer();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    checks++; if (err !== 1'b0) $display("FAIL ptr_errclr got %b want 0", err); else passes++;
  endtask

  task automatic test_collision();
    start_xfer(); rcv(8'h06);
    datareceive = 8'h9A; received = 1'b1; sended = 1'b1; tick(2);
    received = 1'b0; sended = 1'b0; tick(2);
    checks++; if (err !== 1'b1 || datasend !== 8'h00) $display("FAIL collide got err=%b ds=%h want 1 00", err, datasend); else passes++;
    rcv(8'hBC);
    checks++; if (reg_at(6) !== 16'h9ABC) $display("FAIL collide_write got %h want 9abc", reg_at(6)); else passes++;
    stop_xfer();
    err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
    start_xfer();
    datareceive = 8'h30; received = 1'b1; err_clr = 1'b1; tick(1);
    err_clr = 1'b0; tick(1); received = 1'b0; tick(2);
    checks++; if (err !== 1'b1) $display("FAIL err_wins_clr got %b want 1", err); else passes++;
    stop_xfer();
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = stb_cnt;
    start_xfer(); rcv(8'h07); rcv(8'h55);
    datareceive = 8'h66; received = 1'b1; reset = 1'b1; tick(2);
    checks++; if (datasend !== 8'h00 || err !== 1'b0 || wr_stb !== 1'b0) $display("FAIL mid_reset got ds=%h err=%b stb=%b want 00 0 0", datasend, err, wr_stb); else passes++;
    checks++; if (regs_q !== 256'h0) $display("FAIL mid_reset_regs got %h want 0", regs_q); else passes++;
    reset = 1'b0; received = 1'b0; busy = 1'b0; tick(3);
    checks++; if (stb_cnt - c0 !== 0 || reg_at(7) !== 16'h0000) $display("FAIL mid_reset_commit got cnt=%0d r7=%h want 0 0000", stb_cnt - c0, reg_at(7)); else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_chipid();
    test_wrap();
    test_partial();
    test_status();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
